// File: rtl/dvs_event_ingress_if.sv
// Event port between the ingress FIFO head (master) and the gesture accelerator (slave).
// Handshake: an entry transfers on every clk edge where event_valid && event_ready; while
// event_valid is high and no transfer happens, the producer holds all event_* fields stable.
interface dvs_event_ingress_if;
    logic        event_valid;
    logic        event_ready;
    logic [8:0]  event_x;
    logic [8:0]  event_y;
    logic        event_polarity;
    logic [15:0] event_ts;

    modport master (
        output event_valid, event_x, event_y, event_polarity, event_ts,
        input  event_ready
    );

    modport slave (
        input  event_valid, event_x, event_y, event_polarity, event_ts,
        output event_ready
    );
endinterface

// File: rtl/dvs_event_ingress.sv
// DVS event ingress: UART byte parser, range check, inter-byte timeout and show-ahead event FIFO.
// Optional per-event timestamps are built when DVS_INGRESS_TIMESTAMP_EN is defined.
module dvs_event_ingress #(
    parameter int FIFO_DEPTH     = 16,
    parameter int SENSOR_RES     = 320,
    parameter int TIMEOUT_CYCLES = 12000,
    parameter int TS_DIV         = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    dvs_event_ingress_if.master               evt,
    output logic                              cmd_ping,
    output logic                              cmd_query,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic [7:0]                        drop_count,
    output logic [7:0]                        err_count,
    output logic [2:0]                        parser_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_X_HI = 3'd1,
        S_X_LO = 3'd2,
        S_Y_HI = 3'd3,
        S_Y_LO = 3'd4,
        S_POL  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic [8:0]      x_q, y_q;
    logic            ping_d, query_d, err_evt, push_req, timeout_hit;
    logic            byte_is_hi, out_of_range;

    // The x/y high byte carries only bit 8; anything above bit 0 marks a framing error.
    assign byte_is_hi   = (rx_data[7:1] == 7'd0);
    assign out_of_range = (int'(x_q) >= SENSOR_RES) || (int'(y_q) >= SENSOR_RES);
    assign parser_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        ping_d      = 1'b0;
        query_d     = 1'b0;
        err_evt     = 1'b0;
        push_req    = 1'b0;
        timeout_hit = 1'b0;
        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == 8'hFF)      ping_d  = 1'b1;
                    else if (rx_data == 8'hFE) query_d = 1'b1;
                    else if (byte_is_hi)       state_d = S_X_LO;
                    else                       err_evt = 1'b1;
                end
                S_X_LO: state_d = S_Y_HI;
                S_Y_HI: begin
                    if (byte_is_hi) state_d = S_Y_LO;
                    else begin
                        err_evt = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_Y_LO: state_d = S_POL;
                S_POL: begin
                    state_d = S_IDLE;
                    if (out_of_range) err_evt  = 1'b1;
                    else              push_req = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // A byte arriving on the expiry cycle is taken above, so it always beats the abort.
            timeout_hit = 1'b1;
            err_evt     = 1'b1;
            state_d     = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                           timer_q <= '0;
        else if (rx_valid || state_q == S_IDLE || timeout_hit) timer_q <= '0;
        else                                               timer_q <= timer_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (rx_valid) begin
            case (state_q)
                S_IDLE:  if (byte_is_hi) x_q[8] <= rx_data[0];
                S_X_LO:  x_q[7:0] <= rx_data;
                S_Y_HI:  if (byte_is_hi) y_q[8] <= rx_data[0];
                S_Y_LO:  y_q[7:0] <= rx_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ping  <= 1'b0;
            cmd_query <= 1'b0;
        end else begin
            cmd_ping  <= ping_d;
            cmd_query <= query_d;
        end
    end

    logic [8:0]    mem_x   [FIFO_DEPTH];
    logic [8:0]    mem_y   [FIFO_DEPTH];
    logic          mem_pol [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, push, drop_evt;

    // A pop on the same edge frees the slot, so a push into a full FIFO still succeeds then.
    assign full            = (fifo_level == LW'(FIFO_DEPTH));
    assign evt.event_valid = (fifo_level != '0);
    assign pop             = evt.event_valid && evt.event_ready;
    assign push            = push_req && (!full || pop);
    assign drop_evt        = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr]   <= x_q;
            mem_y[wr_ptr]   <= y_q;
            mem_pol[wr_ptr] <= rx_data[0];
        end
    end

    assign evt.event_x        = evt.event_valid ? mem_x[rd_ptr]   : '0;
    assign evt.event_y        = evt.event_valid ? mem_y[rd_ptr]   : '0;
    assign evt.event_polarity = evt.event_valid ? mem_pol[rd_ptr] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
            err_count  <= '0;
        end else begin
            if (drop_evt && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            if (err_evt && err_count != 8'hFF)   err_count  <= err_count + 8'd1;
        end
    end

`ifdef DVS_INGRESS_TIMESTAMP_EN
    localparam int DW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

    logic [DW-1:0] ts_div_q;
    logic [15:0]   ts_q;
    logic [15:0]   mem_ts [FIFO_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_div_q <= '0;
            ts_q     <= '0;
        end else if (ts_div_q == DW'(TS_DIV - 1)) begin
            ts_div_q <= '0;
            ts_q     <= ts_q + 16'd1;
        end else begin
            ts_div_q <= ts_div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_ts[wr_ptr] <= ts_q;
    end

    assign evt.event_ts = evt.event_valid ? mem_ts[rd_ptr] : '0;
`else
    assign evt.event_ts = '0;
`endif
endmodule

// File: tb/tb_dvs_event_ingress.sv
// Self-checking bench for dvs_event_ingress: scenario tasks plus a queue-based event scoreboard.
// Also builds with DVS_INGRESS_TIMESTAMP_EN defined to exercise the timestamp path.
module tb_dvs_event_ingress;
    localparam int W        = 35;
    localparam int DEPTH    = 16;
    localparam int RES      = 320;
    localparam int TIMEOUT  = 12000;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_Y_HI = 3'd3;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_ping, cmd_query;
    logic [4:0] fifo_level;
    logic [7:0] drop_count, err_count;
    logic [2:0] parser_state;

    dvs_event_ingress_if evt_if ();

    dvs_event_ingress #(
        .FIFO_DEPTH(DEPTH), .SENSOR_RES(RES), .TIMEOUT_CYCLES(TIMEOUT), .TS_DIV(12)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .evt(evt_if.master),
        .cmd_ping(cmd_ping), .cmd_query(cmd_query), .fifo_level(fifo_level),
        .drop_count(drop_count), .err_count(err_count), .parser_state(parser_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_err  = 0;
    int exp_drop = 0;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] pack(input logic [8:0] x, input logic [8:0] y, input logic pol);
        return {x, y, pol, 16'h0000};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Sends one packet and updates the reference model before the POL byte is sampled.
    task automatic send_pkt(input logic [8:0] x, input logic [8:0] y, input logic [7:0] pol_byte);
        send_byte({7'd0, x[8]});
        send_byte(x[7:0]);
        send_byte({7'd0, y[8]});
        send_byte(y[7:0]);
        if (int'(x) >= RES || int'(y) >= RES) exp_err++;
        else if (exp_q.size() < DEPTH)         exp_q.push_back(pack(x, y, pol_byte[0]));
        else                                   exp_drop++;
        send_byte(pol_byte);
    endtask

    task automatic sb_pop(input string tag);
        logic [W-1:0] exp_v, act_v;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, event_valid=%0b", tag, evt_if.event_valid);
            return;
        end
        exp_v = exp_q.pop_front();
        act_v = {evt_if.event_x, evt_if.event_y, evt_if.event_polarity, evt_if.event_ts};
`ifdef DVS_INGRESS_TIMESTAMP_EN
        act_v[15:0] = 16'h0;
`endif
        if (evt_if.event_valid !== 1'b1 || act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: valid=%0b got x=%0d y=%0d pol=%0b ts=%0h, want x=%0d y=%0d pol=%0b ts=%0h",
                     tag, evt_if.event_valid, act_v[34:26], act_v[25:17], act_v[16], act_v[15:0],
                     exp_v[34:26], exp_v[25:17], exp_v[16], exp_v[15:0]);
        end
        evt_if.event_ready = 1'b1;
        @(posedge clk); #1;
        evt_if.event_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if ({evt_if.event_valid, fifo_level, drop_count, err_count, cmd_ping, cmd_query,
             evt_if.event_x, evt_if.event_y, evt_if.event_polarity, evt_if.event_ts, parser_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: valid=%0b level=%0d drop=%0d err=%0d ping=%0b query=%0b x=%0d state=%0d, want all 0",
                     evt_if.event_valid, fifo_level, drop_count, err_count, cmd_ping, cmd_query, evt_if.event_x, parser_state);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        send_pkt(9'd42, 9'd261, 8'h01);
        n_checks++;
        if (evt_if.event_valid !== 1'b1 || fifo_level !== 5'd1 || evt_if.event_x !== 9'd42 ||
            evt_if.event_y !== 9'd261 || evt_if.event_polarity !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_head: valid=%0b level=%0d x=%0d y=%0d pol=%0b, want 1 1 42 261 1",
                     evt_if.event_valid, fifo_level, evt_if.event_x, evt_if.event_y, evt_if.event_polarity);
        end
        sb_pop("basic_pop");
        n_checks++;
        if (evt_if.event_valid !== 1'b0 || fifo_level !== 5'd0) begin
            n_fail++;
            $display("FAIL basic_empty: valid=%0b level=%0d, want 0 0", evt_if.event_valid, fifo_level);
        end
    endtask

    task automatic test_commands;
        logic [7:0] pkt [5];
        logic       seen;
        send_byte(8'hFF);
        n_checks++;
        if (cmd_ping !== 1'b1 || cmd_query !== 1'b0) begin
            n_fail++;
            $display("FAIL ping_pulse: ping=%0b query=%0b, want 1 0", cmd_ping, cmd_query);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cmd_ping !== 1'b0) begin
            n_fail++;
            $display("FAIL ping_single: ping=%0b, want 0", cmd_ping);
        end
        send_byte(8'hFE);
        n_checks++;
        if (cmd_query !== 1'b1 || cmd_ping !== 1'b0) begin
            n_fail++;
            $display("FAIL query_pulse: query=%0b ping=%0b, want 1 0", cmd_query, cmd_ping);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cmd_query !== 1'b0) begin
            n_fail++;
            $display("FAIL query_single: query=%0b, want 0", cmd_query);
        end
        pkt  = '{8'h00, 8'hFF, 8'h00, 8'h10, 8'h00};
        seen = 1'b0;
        exp_q.push_back(pack(9'd255, 9'd16, 1'b0));
        for (int i = 0; i < 5; i++) begin
            send_byte(pkt[i]);
            seen = seen | cmd_ping | cmd_query;
        end
        n_checks++;
        if (seen !== 1'b0 || err_count !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL ff_as_data: cmd_seen=%0b err=%0d, want 0 %0d", seen, err_count, exp_err);
        end
        sb_pop("ff_as_data_pop");
    endtask

    task automatic test_errors;
        send_pkt(9'd320, 9'd0, 8'h01);
        n_checks++;
        if (err_count !== 8'd1 || evt_if.event_valid !== 1'b0 || fifo_level !== 5'd0) begin
            n_fail++;
            $display("FAIL x_range: err=%0d valid=%0b level=%0d, want 1 0 0", err_count, evt_if.event_valid, fifo_level);
        end
        send_byte(8'h7B);
        exp_err++;
        n_checks++;
        if (err_count !== 8'd2 || parser_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL idle_junk: err=%0d state=%0d, want 2 0", err_count, parser_state);
        end
        send_byte(8'h00); send_byte(8'h05); send_byte(8'h02);
        exp_err++;
        n_checks++;
        if (err_count !== 8'(exp_err) || parser_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL y_hi_framing: err=%0d state=%0d, want %0d 0", err_count, parser_state, exp_err);
        end
        send_pkt(9'd5, 9'd320, 8'h00);
        send_pkt(9'd319, 9'd319, 8'h01);
        n_checks++;
        if (err_count !== 8'(exp_err) || fifo_level !== 5'd1) begin
            n_fail++;
            $display("FAIL range_edge: err=%0d level=%0d, want %0d 1", err_count, fifo_level, exp_err);
        end
        sb_pop("range_edge_pop");
    endtask

    task automatic test_timeout;
        send_byte(8'h00); send_byte(8'h10);
        repeat (TIMEOUT - 1) @(posedge clk); #1;
        n_checks++;
        if (parser_state !== ST_Y_HI || err_count !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL timeout_early: state=%0d err=%0d, want %0d %0d", parser_state, err_count, ST_Y_HI, exp_err);
        end
        @(posedge clk); #1;
        exp_err++;
        n_checks++;
        if (parser_state !== ST_IDLE || err_count !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL timeout_abort: state=%0d err=%0d, want 0 %0d", parser_state, err_count, exp_err);
        end
        send_pkt(9'd1, 9'd2, 8'h00);
        sb_pop("after_timeout_pop");
        send_byte(8'h00); send_byte(8'h10);
        repeat (TIMEOUT - 1) @(posedge clk); #1;
        send_byte(8'h00);
        send_byte(8'h20);
        exp_q.push_back(pack(9'd16, 9'd32, 1'b1));
        send_byte(8'h01);
        n_checks++;
        if (err_count !== 8'(exp_err) || fifo_level !== 5'd1) begin
            n_fail++;
            $display("FAIL timeout_tie: err=%0d level=%0d, want %0d 1", err_count, fifo_level, exp_err);
        end
        sb_pop("timeout_tie_pop");
    endtask

    task automatic test_overflow;
        logic [8:0]   x, y;
        logic [W-1:0] head;
        for (int i = 0; i < DEPTH + 1; i++)
            send_pkt(9'($urandom_range(0, RES - 1)), 9'($urandom_range(0, RES - 1)), 8'($urandom_range(0, 1)));
        n_checks++;
        if (fifo_level !== 5'd16 || drop_count !== 8'(exp_drop) || exp_drop != 1) begin
            n_fail++;
            $display("FAIL overflow: level=%0d drop=%0d, want 16 1", fifo_level, drop_count);
        end
        x = 9'($urandom_range(0, RES - 1));
        y = 9'($urandom_range(0, RES - 1));
        send_byte({7'd0, x[8]}); send_byte(x[7:0]); send_byte({7'd0, y[8]}); send_byte(y[7:0]);
        head = exp_q.pop_front();
        exp_q.push_back(pack(x, y, 1'b1));
        n_checks++;
        if ({evt_if.event_x, evt_if.event_y, evt_if.event_polarity} !== head[34:16]) begin
            n_fail++;
            $display("FAIL full_pop_head: got x=%0d y=%0d, want x=%0d y=%0d",
                     evt_if.event_x, evt_if.event_y, head[34:26], head[25:17]);
        end
        evt_if.event_ready = 1'b1;
        send_byte(8'hA5);
        evt_if.event_ready = 1'b0;
        n_checks++;
        if (fifo_level !== 5'd16 || drop_count !== 8'(exp_drop)) begin
            n_fail++;
            $display("FAIL full_push_pop: level=%0d drop=%0d, want 16 %0d", fifo_level, drop_count, exp_drop);
        end
        for (int i = 0; i < DEPTH; i++) sb_pop("overflow_drain");
        n_checks++;
        if (fifo_level !== 5'd0 || evt_if.event_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_empty: level=%0d valid=%0b, want 0 0", fifo_level, evt_if.event_valid);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++)
            send_pkt(9'($urandom_range(0, 400)), 9'($urandom_range(0, 400)), 8'($urandom_range(0, 255)));
        n_checks++;
        if (err_count !== 8'(exp_err) || fifo_level !== 5'(exp_q.size()) || drop_count !== 8'(exp_drop)) begin
            n_fail++;
            $display("FAIL back_to_back: err=%0d level=%0d drop=%0d, want %0d %0d %0d",
                     err_count, fifo_level, drop_count, exp_err, exp_q.size(), exp_drop);
        end
        while (exp_q.size() != 0) sb_pop("back_to_back_drain");
    endtask

`ifdef DVS_INGRESS_TIMESTAMP_EN
    task automatic test_timestamp;
        logic [15:0] ts1, ts2;
        send_pkt(9'd10, 9'd20, 8'h00);
        repeat (115) @(posedge clk); #1;
        send_pkt(9'd11, 9'd21, 8'h01);
        ts1 = evt_if.event_ts;
        sb_pop("ts_first_pop");
        ts2 = evt_if.event_ts;
        n_checks++;
        if (16'(ts2 - ts1) !== 16'd10) begin
            n_fail++;
            $display("FAIL ts_delta: ts1=%0d ts2=%0d delta=%0d, want 10", ts1, ts2, 16'(ts2 - ts1));
        end
        sb_pop("ts_second_pop");
    endtask
`endif

    task automatic test_reset_mid;
        send_pkt(9'd7, 9'd8, 8'h01);
        send_pkt(9'd9, 9'd10, 8'h00);
        send_byte(8'h00); send_byte(8'h07);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (evt_if.event_valid !== 1'b0 || fifo_level !== 5'd0 || drop_count !== 8'd0 || err_count !== 8'd0 ||
            parser_state !== ST_IDLE || evt_if.event_x !== 9'd0 || cmd_ping !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%0b level=%0d drop=%0d err=%0d state=%0d x=%0d, want all 0",
                     evt_if.event_valid, fifo_level, drop_count, err_count, parser_state, evt_if.event_x);
        end
        exp_q.delete();
        exp_err  = 0;
        exp_drop = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        send_pkt(9'd3, 9'd4, 8'h01);
        n_checks++;
        if (fifo_level !== 5'd1 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL post_reset_pkt: level=%0d err=%0d, want 1 0", fifo_level, err_count);
        end
        sb_pop("post_reset_pop");
    endtask

    initial begin
        rst                = 1'b1;
        rx_data            = 8'h00;
        rx_valid           = 1'b0;
        evt_if.event_ready = 1'b0;
        test_reset();
        test_basic();
        test_commands();
        test_errors();
        test_timeout();
        test_overflow();
        test_back_to_back();
`ifdef DVS_INGRESS_TIMESTAMP_EN
        test_timestamp();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
